// File: rtl/dmem_if_if.sv
// Load/store unit <-> data SRAM bundle: request, SRAM and response channels.
// The master side is the core plus SRAM; the slave side is dmem_if.
interface dmem_if_if #(
    parameter int AW      = 16,
    parameter int SRAM_AW = 14
);
    logic               req_vld;
    logic               req_rdy;
    logic               req_we;
    logic [2:0]         req_f3;
    logic [AW-1:0]      req_a;
    logic [31:0]        req_wd;
    logic [4:0]         req_tag;

    logic [SRAM_AW-1:0] sram_a;
    logic [3:0]         sram_we;
    logic [31:0]        sram_wd;
    logic [3:0]         sram_re;
    logic [31:0]        sram_rd;

    logic               rsp_vld;
    logic               rsp_rdy;
    logic [31:0]        rsp_d;
    logic [4:0]         rsp_tag;
    logic               rsp_err;

    modport master (
        output req_vld, req_we, req_f3, req_a, req_wd, req_tag,
        input  req_rdy,
        input  sram_a, sram_we, sram_wd, sram_re,
        output sram_rd,
        input  rsp_vld, rsp_d, rsp_tag, rsp_err,
        output rsp_rdy
    );

    modport slave (
        input  req_vld, req_we, req_f3, req_a, req_wd, req_tag,
        output req_rdy,
        output sram_a, sram_we, sram_wd, sram_re,
        input  sram_rd,
        output rsp_vld, rsp_d, rsp_tag, rsp_err,
        input  rsp_rdy
    );
endinterface

// File: rtl/dmem_if.sv
// Data-memory interface: issues byte-enabled SRAM accesses, formats load data one
// cycle later and returns one in-order response per accepted request through a FIFO.
module dmem_if #(
    parameter int AW      = 16,
    parameter int SRAM_AW = 14,
    parameter int DEPTH   = 3
) (
    input  logic     clk,
    input  logic     rstn,
    dmem_if_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  tag;
        logic        err;
    } rsp_t;

    logic          acc, req_rdy, err, st_ok, ld_ok;
    logic [1:0]    off, size;
    logic [3:0]    be;

    logic          b_vld_q, b_vld_d, b_we_q, b_we_d, b_err_q, b_err_d;
    logic [2:0]    b_f3_q, b_f3_d;
    logic [1:0]    b_off_q, b_off_d;
    logic [4:0]    b_tag_q, b_tag_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    rsp_t          fifo_q [DEPTH];
    rsp_t          entry_d;
    logic          push, pop, rsp_vld;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Issue stage: admission depends only on registered state, never on rsp_rdy.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        off     = bus.req_a[1:0];
        size    = bus.req_f3[1:0];
        req_rdy = !rstn && ((int'(occ_q) + int'(b_vld_q)) < DEPTH);
        acc     = bus.req_vld && req_rdy;
        err     = (size == 2'd3) || (bus.req_f3[2] && (bus.req_f3[1] || bus.req_we))
               || ((size == 2'd1) && off[0]) || ((size == 2'd2) && (off != 2'd0));
        be      = '0;
        case (size)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = 4'b0011 << off;
            2'd2:    be = 4'b1111;
            default: be = '0;
        endcase
        st_ok = acc && bus.req_we && !err;
        ld_ok = acc && !bus.req_we && !err;

        bus.req_rdy = req_rdy;
        bus.sram_we = st_ok ? be : '0;
        bus.sram_re = ld_ok ? be : '0;
        bus.sram_a  = acc ? bus.req_a[SRAM_AW+1:2] : '0;
        bus.sram_wd = '0;
        if (st_ok) begin
            case (size)
                2'd0:    bus.sram_wd = {4{bus.req_wd[7:0]}};
                2'd1:    bus.sram_wd = {2{bus.req_wd[15:0]}};
                default: bus.sram_wd = bus.req_wd;
            endcase
        end
    end

    always_comb begin
        b_vld_d = acc;
        b_we_d  = b_we_q;
        b_f3_d  = b_f3_q;
        b_off_d = b_off_q;
        b_tag_d = b_tag_q;
        b_err_d = b_err_q;
        if (acc) begin
            b_we_d  = bus.req_we;
            b_f3_d  = bus.req_f3;
            b_off_d = off;
            b_tag_d = bus.req_tag;
            b_err_d = err;
        end
    end

    // Stage B: lane select and extension of the word read in the previous cycle.
    always_comb begin
        rd_byte = bus.sram_rd[{b_off_q, 3'b000} +: 8];
        rd_half = bus.sram_rd[{b_off_q[1], 4'b0000} +: 16];
        entry_d = '{d: '0, tag: b_tag_q, err: b_err_q};
        if (!b_we_q && !b_err_q) begin
            case (b_f3_q)
                3'd0:    entry_d.d = {{24{rd_byte[7]}}, rd_byte};
                3'd4:    entry_d.d = {24'd0, rd_byte};
                3'd1:    entry_d.d = {{16{rd_half[15]}}, rd_half};
                3'd5:    entry_d.d = {16'd0, rd_half};
                3'd2:    entry_d.d = bus.sram_rd;
                default: entry_d.d = '0;
            endcase
        end
    end

    // A push into a full FIFO only happens alongside a pop, so occupancy never exceeds DEPTH.
    always_comb begin
        rsp_vld  = (occ_q != '0);
        push     = b_vld_q;
        pop      = rsp_vld && bus.rsp_rdy;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q + OW'(push) - OW'(pop);

        bus.rsp_vld = rsp_vld;
        bus.rsp_d   = rsp_vld ? fifo_q[rd_ptr_q].d   : '0;
        bus.rsp_tag = rsp_vld ? fifo_q[rd_ptr_q].tag : '0;
        bus.rsp_err = rsp_vld ? fifo_q[rd_ptr_q].err : 1'b0;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            b_vld_q  <= 1'b0;
            b_we_q   <= 1'b0;
            b_f3_q   <= '0;
            b_off_q  <= '0;
            b_tag_q  <= '0;
            b_err_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            b_vld_q  <= b_vld_d;
            b_we_q   <= b_we_d;
            b_f3_q   <= b_f3_d;
            b_off_q  <= b_off_d;
            b_tag_q  <= b_tag_d;
            b_err_q  <= b_err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: payload storage is not reset; occupancy gates every read of it.
        if (push) fifo_q[wr_ptr_q] <= entry_d;
    end
endmodule

// File: tb/tb_dmem_if.sv
// Self-checking bench for dmem_if: byte-level memory model and an in-order
// expected-response queue, driven by directed cases and random traffic.
module tb_dmem_if;
    localparam int AW      = 16;
    localparam int SRAM_AW = 14;
    localparam int DEPTH   = 3;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  tag;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    dmem_if_if #(.AW(AW), .SRAM_AW(SRAM_AW)) bus ();
    dmem_if #(.AW(AW), .SRAM_AW(SRAM_AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    exp_t        exp_q[$];
    logic [31:0] sram_mem [1 << SRAM_AW];
    logic [7:0]  ref_mem  [1 << AW];
    int          n_vec     = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          acc_total = 0;
    int          rdy_mode  = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int w);
        return (w == 4) ? 32'h8899AABB : ((32'(w) * 32'h9E3779B1) ^ 32'h5A5AC3C3);
    endfunction

    // Reference: access size from funct3, natural alignment, little-endian byte memory.
    function automatic void model_req(input logic we, input logic [2:0] f3, input logic [15:0] a,
                                      input logic [31:0] wd, output logic [3:0] be,
                                      output logic [31:0] wdo, output logic [31:0] d,
                                      output logic err);
        int sz;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        if (we && f3 > 3'd2) sz = 0;
        if (sz == 0) err = 1'b1;
        else         err = ((int'(a) % sz) != 0);
        be  = '0;
        wdo = '0;
        d   = '0;
        if (!err) begin
            be = 4'(((1 << sz) - 1) << a[1:0]);
            if (we) begin
                for (int i = 0; i < 4; i++) wdo[8*i +: 8] = wd[8*(i % sz) +: 8];
                for (int i = 0; i < sz; i++) ref_mem[a + 16'(i)] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[a + 16'(i)];
                if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1])
                    for (int i = 8 * sz; i < 32; i++) v[i] = 1'b1;
                d = v;
            end
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.rsp_rdy = 1'b0;
            1:       bus.rsp_rdy = 1'b1;
            default: bus.rsp_rdy = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Synchronous SRAM: write at the edge, read data available in the next cycle.
    initial begin
        for (int w = 0; w < (1 << SRAM_AW); w++) sram_mem[w] = init_word(w);
        forever begin
            @(posedge clk);
            for (int i = 0; i < 4; i++)
                if (bus.sram_we[i]) sram_mem[bus.sram_a][8*i +: 8] <= bus.sram_wd[8*i +: 8];
            bus.sram_rd <= (|bus.sram_re) ? sram_mem[bus.sram_a] : $urandom;
        end
    end

    // Monitor, sampling on the falling edge.
    initial begin
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_d, w;
        logic        e_err, acc, e_vld;
        for (int ad = 0; ad < (1 << AW); ad++) begin
            w = init_word(ad >> 2);
            ref_mem[ad] = w[8*(ad % 4) +: 8];
        end
        forever begin
            @(negedge clk);
            if (rstn) begin
                exp_q.delete();
                check("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
                check("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
                check("rst_rsp_d",   bus.rsp_d, 32'd0);
                check("rst_sram_we", 32'(bus.sram_we), 32'd0);
                check("rst_sram_re", 32'(bus.sram_re), 32'd0);
            end else begin
                check("req_rdy", 32'(bus.req_rdy), 32'(exp_q.size() < DEPTH));
                e_vld = (exp_q.size() != 0) && (exp_q[0].cyc <= cyc - 2);
                check("rsp_vld", 32'(bus.rsp_vld), 32'(e_vld));
                if (bus.rsp_vld && e_vld) begin
                    check("rsp_d",   bus.rsp_d, exp_q[0].d);
                    check("rsp_tag", 32'(bus.rsp_tag), 32'(exp_q[0].tag));
                    check("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
                    if (bus.rsp_rdy === 1'b1) void'(exp_q.pop_front());
                end
                acc  = bus.req_vld && bus.req_rdy;
                e_be = '0;
                e_wd = '0;
                if (acc) begin
                    model_req(bus.req_we, bus.req_f3, bus.req_a, bus.req_wd, e_be, e_wd, e_d, e_err);
                    acc_total++;
                    exp_q.push_back('{e_d, bus.req_tag, e_err, cyc});
                end
                check("sram_we", 32'(bus.sram_we), 32'((acc && bus.req_we) ? e_be : 4'd0));
                check("sram_re", 32'(bus.sram_re), 32'((acc && !bus.req_we) ? e_be : 4'd0));
                check("sram_wd", bus.sram_wd, e_wd);
                check("sram_a",  32'(bus.sram_a), acc ? 32'(bus.req_a[15:2]) : 32'd0);
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [15:0] a,
                         input logic [31:0] wd, input logic [4:0] tag);
        int n = 0;
        bus.req_vld = 1'b1;
        bus.req_we  = we;
        bus.req_f3  = f3;
        bus.req_a   = a;
        bus.req_wd  = wd;
        bus.req_tag = tag;
        @(negedge clk);
        while (!bus.req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("issue_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.req_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (exp_q.size() != 0 && n < 200);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          n0, c0;
        logic        we;
        logic [2:0]  f3;
        logic [15:0] a;
        bus.req_vld = 1'b0;
        bus.req_we  = 1'b0;
        bus.req_f3  = '0;
        bus.req_a   = '0;
        bus.req_wd  = '0;
        bus.req_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        idle(1);

        issue(1'b0, 3'd2, 16'h0010, 32'h0, 5'd7);
        issue(1'b1, 3'd0, 16'h0013, 32'h000000C3, 5'd8);
        issue(1'b0, 3'd0, 16'h0013, 32'h0, 5'd9);
        issue(1'b0, 3'd4, 16'h0013, 32'h0, 5'd10);
        issue(1'b0, 3'd1, 16'h0001, 32'h0, 5'd11);
        issue(1'b1, 3'd2, 16'h0002, 32'hDEADBEEF, 5'd12);
        drain();

        // Backpressure: six cycles of offered loads against a stalled consumer.
        rdy_mode    = 0;
        n0          = acc_total;
        bus.req_vld = 1'b1;
        bus.req_we  = 1'b0;
        bus.req_f3  = 3'd2;
        for (int i = 0; i < 6; i++) begin
            bus.req_a   = 16'(32 + 4 * i);
            bus.req_tag = 5'(16 + i);
            @(posedge clk);
            #1;
        end
        check("bp_accepts", 32'(acc_total - n0), 32'd3);
        check("bp_req_rdy", 32'(bus.req_rdy), 32'd0);
        bus.req_vld = 1'b0;
        rdy_mode    = 1;
        drain();
        check("bp_rdy_back", 32'(bus.req_rdy), 32'd1);

        c0 = cyc;
        for (int i = 0; i < 8; i++) issue(1'b0, 3'd2, 16'(4 * i), 32'h0, 5'(i));
        check("b2b_cycles", 32'(cyc - c0), 32'd8);
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                we = 1'($urandom_range(0, 1));
                if (we) f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                else    f3 = 3'($urandom_range(0, 7));
                a = 16'($urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                if ($urandom_range(0, 7) == 0) a[15:14] = 2'($urandom_range(0, 3));
                issue(we, f3, a, $urandom, 5'($urandom));
            end
        end
        rdy_mode = 1;
        drain();

        // Reset with one response queued and one request in stage B.
        rdy_mode = 0;
        issue(1'b0, 3'd2, 16'h0010, 32'h0, 5'd1);
        issue(1'b0, 3'd0, 16'h0013, 32'h0, 5'd2);
        bus.req_vld = 1'b1;
        rstn        = 1'b1;
        #1;
        check("mid_rst_req_rdy", 32'(bus.req_rdy), 32'd0);
        check("mid_rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
        check("mid_rst_rsp_d",   bus.rsp_d, 32'd0);
        check("mid_rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("mid_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("mid_rst_sram_re", 32'(bus.sram_re), 32'd0);
        check("mid_rst_sram_a",  32'(bus.sram_a), 32'd0);
        check("mid_rst_sram_wd", bus.sram_wd, 32'd0);
        bus.req_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn     = 1'b0;
        rdy_mode = 1;
        idle(6);
        check("post_rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
